// File: rtl/io_panel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_panel_pkg
// Description : Shared constants for the IO panel: display geometry, the
//               blank segment pattern and the hex to seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package io_panel_pkg;

    localparam int         NUM_DIGITS  = 8;
    localparam int         USED_DIGITS = 6;
    localparam logic [7:0] BLANK_SEG   = 8'hFF;

    // Active-low segment codes {dp,g,f,e,d,c,b,a}, nibble 0 in the low byte.
    // The dp bit is high in every entry, so the decimal point stays dark.
    localparam logic [127:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[{nib, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_debounce.sv
`default_nettype none
// ============================================================================
// Module      : vec_debounce
// Description : Two-flop synchroniser followed by a whole-vector debouncer.
//               Any bit change restarts the stability window; the vector is
//               published once it has stayed unchanged for DEBOUNCE_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_debounce
    import io_panel_pkg::*;
#(
    parameter int WIDTH           = 24,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int                c_dcnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_dcnt_w-1:0] c_dcnt_max = c_dcnt_w'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]    r_meta;
    logic [WIDTH-1:0]    r_sync;
    logic [WIDTH-1:0]    r_cand;
    logic [WIDTH-1:0]    r_out;
    logic [c_dcnt_w-1:0] r_dcnt;

    // Bring the asynchronous switch vector into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
        end
    end

    // Track the candidate vector and publish it after a full quiet window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand <= '0;
            r_dcnt <= '0;
            r_out  <= '0;
        end else if (r_sync != r_cand) begin
            r_cand <= r_sync;
            r_dcnt <= '0;
        end else if (r_dcnt == c_dcnt_max) begin
            r_out  <= r_cand;
        end else begin
            r_dcnt <= r_dcnt + 1'b1;
        end
    end

    assign dout = r_out;

endmodule
`default_nettype wire

// File: rtl/io_panel.sv
`default_nettype none
// ============================================================================
// Module      : io_panel
// Description : CPU IO port stage. Writes latch onto 24 LEDs and a scanned
//               8-digit seven-segment display (6 hex digits shown, 2 blank);
//               reads return the synchronised, debounced switch vector.
// Revision    : 1.0 - initial release
// ============================================================================
module io_panel
    import io_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int SCAN_CYCLES     = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_write,
    input  logic [23:0] io_wdata,
    output logic [23:0] io_rdata,
    input  logic [23:0] sw_raw,
    output logic [23:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam int c_scan_w  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int c_digit_w = $clog2(NUM_DIGITS);
    localparam logic [c_scan_w-1:0]  c_scan_max = c_scan_w'(SCAN_CYCLES - 1);
    localparam logic [c_digit_w-1:0] c_used     = c_digit_w'(USED_DIGITS);

    logic [23:0]          r_led;
    logic [c_scan_w-1:0]  r_scnt;
    logic [c_digit_w-1:0] r_digit;
    logic [7:0]           r_seg_an;
    logic [7:0]           r_seg_cat;
    logic [3:0]           w_nib [NUM_DIGITS];
    logic [7:0]           w_an;
    logic [7:0]           w_cat;

    vec_debounce #(
        .WIDTH           (24),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (sw_raw),
        .dout (io_rdata)
    );

    // LED register loads only on a qualified CPU IO write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else if (io_write) begin
            r_led <= io_wdata;
        end
    end

    // Dwell counter and active digit; the digit index wraps 7 -> 0 naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scnt  <= '0;
            r_digit <= '0;
        end else if (r_scnt == c_scan_max) begin
            r_scnt  <= '0;
            r_digit <= r_digit + 1'b1;
        end else begin
            r_scnt  <= r_scnt + 1'b1;
        end
    end

    // Per-digit nibble view of the LED word; unused digit slots read as zero.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
        if (i < USED_DIGITS) begin : g_used
            assign w_nib[i] = r_led[4*i +: 4];
        end else begin : g_blank
            assign w_nib[i] = 4'h0;
        end
    end

    // Decode the active digit into anode enable and segment pattern.
    always_comb begin
        w_an  = BLANK_SEG;
        w_cat = BLANK_SEG;
        if (r_digit < c_used) begin
            w_an  = ~(8'b1 << r_digit);
            w_cat = hex_to_seg(w_nib[r_digit]);
        end
    end

    // Register the display drive so the pins are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_an  <= 8'hFE;
            r_seg_cat <= 8'hC0;
        end else begin
            r_seg_an  <= w_an;
            r_seg_cat <= w_cat;
        end
    end

    assign led     = r_led;
    assign seg_an  = r_seg_an;
    assign seg_cat = r_seg_cat;

endmodule
`default_nettype wire

// File: tb/tb_io_panel.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_panel
// Description : Directed self-checking bench for io_panel with
//               DEBOUNCE_CYCLES=4 and SCAN_CYCLES=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_panel;

    logic        clk;
    logic        rst;
    logic        io_write;
    logic [23:0] io_wdata;
    logic [23:0] io_rdata;
    logic [23:0] sw_raw;
    logic [23:0] led;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_an  [16];
    logic [7:0] exp_cat [16];

    io_panel #(
        .DEBOUNCE_CYCLES (4),
        .SCAN_CYCLES     (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_write (io_write),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .sw_raw   (sw_raw),
        .led      (led),
        .seg_an   (seg_an),
        .seg_cat  (seg_cat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdata"}, io_rdata, 24'h0);
        chk({tag, "_led"}, led, 24'h0);
        chk({tag, "_an"}, {16'h0, seg_an}, 24'h0000FE);
        chk({tag, "_cat"}, {16'h0, seg_cat}, 24'h0000C0);
    endtask

    initial begin
        // Scan view after a write of 123456 at the first edge out of reset,
        // starting with the second edge.
        exp_an  = '{8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hF7, 8'hF7, 8'hEF,
                    8'hEF, 8'hDF, 8'hDF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
        exp_cat = '{8'h82, 8'h92, 8'h92, 8'h99, 8'h99, 8'hB0, 8'hB0, 8'hA4,
                    8'hA4, 8'hF9, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h82};

        rst      = 1'b0;
        io_write = 1'b0;
        io_wdata = 24'h0;
        sw_raw   = 24'h0;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_reset");
        ticks(2);
        rst = 1'b0;

        // Stable switch input: published at edge N+6.
        sw_raw = 24'h00A5F0;
        ticks(6);
        chk("sw_not_before", io_rdata, 24'h0);
        ticks(1);
        chk("sw_latency", io_rdata, 24'h00A5F0);
        chk("led_idle", led, 24'h0);

        // Return to zero, then glitch rejection.
        sw_raw = 24'h0;
        ticks(8);
        chk("sw_back_zero", io_rdata, 24'h0);
        sw_raw = 24'h000001;
        ticks(2);
        sw_raw = 24'h0;
        for (int i = 0; i < 20; i++) begin
            ticks(1);
            chk("glitch_reject", io_rdata, 24'h0);
        end

        // Write and scan, from a known scan phase.
        #2 rst = 1'b1;
        ticks(1);
        rst      = 1'b0;
        io_write = 1'b1;
        io_wdata = 24'h123456;
        ticks(1);
        io_write = 1'b0;
        io_wdata = 24'h0;
        chk("write_led", led, 24'h123456);
        chk("write_cat_prev", {16'h0, seg_cat}, 24'h0000C0);
        for (int i = 0; i < 16; i++) begin
            ticks(1);
            chk("scan_an", {16'h0, seg_an}, {16'h0, exp_an[i]});
            chk("scan_cat", {16'h0, seg_cat}, {16'h0, exp_cat[i]});
        end

        // Strobe qualification and back-to-back writes.
        io_wdata = 24'hABCDEF;
        ticks(3);
        chk("no_strobe", led, 24'h123456);
        io_write = 1'b1;
        io_wdata = 24'h111111;
        ticks(1);
        chk("b2b_first", led, 24'h111111);
        io_wdata = 24'h222222;
        ticks(1);
        chk("b2b_second", led, 24'h222222);
        io_write = 1'b0;
        io_wdata = 24'h333333;
        ticks(1);
        chk("b2b_hold", led, 24'h222222);

        // Reset mid-operation at digit 3 with all LEDs lit.
        sw_raw = 24'h5A5A5A;
        #2 rst = 1'b1;
        ticks(1);
        rst      = 1'b0;
        io_write = 1'b1;
        io_wdata = 24'hFFFFFF;
        ticks(1);
        io_write = 1'b0;
        chk("mid_led", led, 24'hFFFFFF);
        ticks(5);
        chk("mid_sw_not_before", io_rdata, 24'h0);
        ticks(1);
        chk("mid_sw", io_rdata, 24'h5A5A5A);
        chk("mid_an_d3", {16'h0, seg_an}, 24'h0000F7);
        chk("mid_cat_d3", {16'h0, seg_cat}, 24'h00008E);
        #2 rst = 1'b1;
        io_write = 1'b1;
        io_wdata = 24'h777777;
        #1 chk_reset_outputs("mid_reset");
        ticks(1);
        rst      = 1'b0;
        io_write = 1'b0;
        ticks(1);
        chk("post_led", led, 24'h0);
        chk("post_an0", {16'h0, seg_an}, 24'h0000FE);
        chk("post_cat0", {16'h0, seg_cat}, 24'h0000C0);
        ticks(1);
        chk("post_an0_dwell", {16'h0, seg_an}, 24'h0000FE);
        ticks(1);
        chk("post_an1", {16'h0, seg_an}, 24'h0000FD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
